// File: rtl/jk_excitation_gen.sv
// jk_excitation_gen
// Produces the per-bit J/K drive that moves an external bank of WIDTH JK
// flip-flops from its present state to a target word accepted over a
// valid/ready handshake. An internal copy of the bank Q (q_model) is advanced
// on the same edge the bank samples j/k, and driving stops once it matches.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (shared with bank)
//   tgt_valid/ready target offer handshake; ready is high only in IDLE
//   tgt_data        desired bank Q
//   tgt_step        1 = one bit per cycle (lowest differing first), 0 = all
//   tgt_tog         1 = toggle encoding (J=K=1), 0 = explicit set/reset
//   j, k            registered excitation to the bank
//   q_model         modelled bank Q
//   done            one-cycle pulse when q_model reaches the latched target
//   step_cnt        saturating count of edges that loaded a nonzero j|k
//
// state | meaning
// IDLE  | j=k=0, waiting for a target offer
// DRIVE | applying j/k each edge until q_model equals the latched target
module jk_excitation_gen #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_step,
  input  logic             tgt_tog,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q_model,
  output logic             done,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             step_q, step_d, tog_q, tog_d;
  logic [WIDTH-1:0] j_d, k_d, q_d;
  logic             done_d;
  logic [CNT_W-1:0] cnt_d;

  logic [WIDTH-1:0] q_next, pat_diff, pat_q, sel, pj, pk;
  logic             mode_step, mode_tog;

  // Pattern generation. In IDLE the pattern is built from the offered target
  // against the current model; in DRIVE it is built from the state the bank
  // will hold after this edge against the latched target.
  always_comb begin
    // JK apply: 00 hold, 01 clear, 10 set, 11 invert
    q_next = (j & ~q_model) | (~k & q_model);
    if (state_q == IDLE) begin
      pat_diff  = q_model ^ tgt_data;
      pat_q     = q_model;
      mode_step = tgt_step;
      mode_tog  = tgt_tog;
    end else begin
      pat_diff  = q_next ^ tgt_q;
      pat_q     = q_next;
      mode_step = step_q;
      mode_tog  = tog_q;
    end
    // two's-complement trick isolates the lowest set bit
    sel = mode_step ? (pat_diff & (~pat_diff + WIDTH'(1))) : pat_diff;
    pj  = mode_tog ? sel : (sel & ~pat_q);
    pk  = mode_tog ? sel : (sel & pat_q);
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    tog_d   = tog_q;
    j_d     = j;
    k_d     = k;
    q_d     = q_model;
    done_d  = 1'b0;
    cnt_d   = step_cnt;
    case (state_q)
      IDLE: begin
        j_d = '0;
        k_d = '0;
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          step_d  = tgt_step;
          tog_d   = tgt_tog;
          j_d     = pj;
          k_d     = pk;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        q_d = q_next;
        if (pat_diff == '0) begin
          j_d     = '0;
          k_d     = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          j_d = pj;
          k_d = pk;
        end
      end
      default: state_d = IDLE;
    endcase
    if (((j_d | k_d) != '0) && (step_cnt != '1))
      cnt_d = step_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tgt_q    <= '0;
      step_q   <= 1'b0;
      tog_q    <= 1'b0;
      j        <= '0;
      k        <= '0;
      q_model  <= '0;
      done     <= 1'b0;
      step_cnt <= '0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      tog_q    <= tog_d;
      j        <= j_d;
      k        <= k_d;
      q_model  <= q_d;
      done     <= done_d;
      step_cnt <= cnt_d;
    end
  end

  assign tgt_ready = (state_q == IDLE);

endmodule
